// File: rtl/cm0_dap_multi_ap_bridge.sv
// DCLK-domain bridge from the DP/AP toggle handshake to NUM_AP memory-access ports.
// One transfer at a time: capture, issue one-cycle slvtrans, wait for ready or timeout, acknowledge.
module cm0_dap_multi_ap_bridge #(
    parameter int unsigned NUM_AP  = 2,
    parameter int unsigned APSEL_W = 4,
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned TO_W    = 9
) (
    input  logic                   dclk,
    input  logic                   apreset,
    input  logic                   dp_req,
    output logic                   ap_ack,
    input  logic [APSEL_W-1:0]     req_apsel,
    input  logic                   req_write,
    input  logic [1:0]             req_size,
    input  logic [31:0]            req_addr,
    input  logic [31:0]            req_wdata,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic                   rsp_timeout,
    input  logic [NUM_AP-1:0]      deviceen,
    output logic [NUM_AP-1:0]      slvtrans,
    output logic [31:0]            slvaddr,
    output logic [31:0]            slvwdata,
    output logic                   slvwrite,
    output logic [1:0]             slvsize,
    input  logic [32*NUM_AP-1:0]   slvrdata,
    input  logic [NUM_AP-1:0]      slvready,
    input  logic [NUM_AP-1:0]      slvresp
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam bit            TO_EN   = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [1:0]          state, state_nxt;
    logic [APSEL_W-1:0]  sel, sel_nxt;
    logic [TO_W-1:0]     cnt, cnt_nxt;
    logic                ack_nxt;
    logic [NUM_AP-1:0]   trans_nxt;
    logic [31:0]         addr_nxt, wdata_nxt, rdata_nxt;
    logic                write_nxt, err_nxt, to_nxt;
    logic [1:0]          size_nxt;

    logic                cap_hit, cap_en;
    logic [NUM_AP-1:0]   cap_onehot;
    logic                sel_ready, sel_resp;
    logic [31:0]         sel_rdata;

    // Decode the incoming select and mux the currently selected port's response.
    always_comb begin
        cap_hit    = 1'b0;
        cap_en     = 1'b0;
        cap_onehot = '0;
        sel_ready  = 1'b0;
        sel_resp   = 1'b0;
        sel_rdata  = '0;
        for (int i = 0; i < int'(NUM_AP); i++) begin
            if (req_apsel == APSEL_W'(i)) begin
                cap_hit       = 1'b1;
                cap_en        = deviceen[i];
                cap_onehot[i] = 1'b1;
            end
            if (sel == APSEL_W'(i)) begin
                sel_ready = slvready[i];
                sel_resp  = slvresp[i];
                sel_rdata = slvrdata[32*i +: 32];
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        cnt_nxt   = cnt;
        ack_nxt   = ap_ack;
        trans_nxt = '0;
        addr_nxt  = slvaddr;
        wdata_nxt = slvwdata;
        write_nxt = slvwrite;
        size_nxt  = slvsize;
        rdata_nxt = rsp_rdata;
        err_nxt   = rsp_err;
        to_nxt    = rsp_timeout;
        case (state)
            ST_IDLE: begin
                if (dp_req != ap_ack) begin
                    addr_nxt  = req_addr;
                    wdata_nxt = req_wdata;
                    write_nxt = req_write;
                    size_nxt  = req_size;
                    sel_nxt   = req_apsel;
                    rdata_nxt = '0;
                    err_nxt   = 1'b0;
                    to_nxt    = 1'b0;
                    // Absent APs read as zero; disabled APs fault without a bus access.
                    if (!cap_hit) begin
                        state_nxt = ST_DONE;
                    end else if (!cap_en) begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_DONE;
                    end else begin
                        trans_nxt = cap_onehot;
                        state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_nxt   = '0;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (sel_ready) begin
                    err_nxt   = sel_resp;
                    rdata_nxt = (!slvwrite && !sel_resp) ? sel_rdata : 32'h0;
                    state_nxt = ST_DONE;
                end else if (TO_EN && (cnt == TO_LAST)) begin
                    err_nxt   = 1'b1;
                    to_nxt    = 1'b1;
                    rdata_nxt = '0;
                    state_nxt = ST_DONE;
                end else begin
                    cnt_nxt = cnt + TO_W'(1);
                end
            end
            ST_DONE: begin
                ack_nxt   = ~ap_ack;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge dclk) begin
        if (apreset) begin
            state       <= ST_IDLE;
            sel         <= '0;
            cnt         <= '0;
            ap_ack      <= 1'b0;
            slvtrans    <= '0;
            slvaddr     <= '0;
            slvwdata    <= '0;
            slvwrite    <= 1'b0;
            slvsize     <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            sel         <= sel_nxt;
            cnt         <= cnt_nxt;
            ap_ack      <= ack_nxt;
            slvtrans    <= trans_nxt;
            slvaddr     <= addr_nxt;
            slvwdata    <= wdata_nxt;
            slvwrite    <= write_nxt;
            slvsize     <= size_nxt;
            rsp_rdata   <= rdata_nxt;
            rsp_err     <= err_nxt;
            rsp_timeout <= to_nxt;
        end
    end

endmodule

// File: tb/tb_cm0_dap_multi_ap_bridge.sv
// Scoreboard bench for cm0_dap_multi_ap_bridge: requests push expected responses,
// an ack monitor pops and compares, and a slave model answers bus transfers.
module tb_cm0_dap_multi_ap_bridge;

    localparam int unsigned NUM_AP = 2;

    logic                 dclk = 1'b0;
    logic                 apreset;
    logic                 dp_req;
    logic                 ap_ack;
    logic [3:0]           req_apsel;
    logic                 req_write;
    logic [1:0]           req_size;
    logic [31:0]          req_addr;
    logic [31:0]          req_wdata;
    logic [31:0]          rsp_rdata;
    logic                 rsp_err;
    logic                 rsp_timeout;
    logic [NUM_AP-1:0]    deviceen;
    logic [NUM_AP-1:0]    slvtrans;
    logic [31:0]          slvaddr;
    logic [31:0]          slvwdata;
    logic                 slvwrite;
    logic [1:0]           slvsize;
    logic [32*NUM_AP-1:0] slvrdata;
    logic [NUM_AP-1:0]    slvready;
    logic [NUM_AP-1:0]    slvresp;

    cm0_dap_multi_ap_bridge #(
        .NUM_AP(NUM_AP), .APSEL_W(4), .TIMEOUT(8), .TO_W(4)
    ) dut (
        .dclk(dclk), .apreset(apreset), .dp_req(dp_req), .ap_ack(ap_ack),
        .req_apsel(req_apsel), .req_write(req_write), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .deviceen(deviceen), .slvtrans(slvtrans), .slvaddr(slvaddr),
        .slvwdata(slvwdata), .slvwrite(slvwrite), .slvsize(slvsize),
        .slvrdata(slvrdata), .slvready(slvready), .slvresp(slvresp)
    );

    always #5 dclk = ~dclk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
        int          lat;
        int          t0;      // -1: captured the cycle after the previous ack
        logic [1:0]  mask;
        int          tcnt;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr;
        logic [1:0]  size;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_mon;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   ack_cnt = 0;
    int   last_ack = 0;
    int   cfg_wait = 0;
    logic cfg_resp = 1'b0;
    logic chk_hold = 1'b1;
    logic [31:0] hold_addr, hold_wdata;
    logic hold_wr;

    always @(posedge dclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_ap_ack", 32'(ap_ack), 32'h0);
        chk("rst_slvtrans", 32'(slvtrans), 32'h0);
        chk("rst_slvaddr", slvaddr, 32'h0);
        chk("rst_slvwdata", slvwdata, 32'h0);
        chk("rst_slvwrite", 32'(slvwrite), 32'h0);
        chk("rst_slvsize", 32'(slvsize), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        chk("rst_rsp_timeout", 32'(rsp_timeout), 32'h0);
    endtask

    // Ack monitor: pops the scoreboard on every ap_ack toggle.
    logic       ack_prev = 1'b0;
    logic [1:0] tmask = '0;
    int         tcnt = 0;
    int         t0_mon;
    always @(negedge dclk) begin
        if (apreset) begin
            ack_prev = ap_ack;
            tmask    = '0;
            tcnt     = 0;
        end else begin
            if (slvtrans != '0) begin
                tmask |= slvtrans;
                tcnt++;
            end
            if (ap_ack != ack_prev) begin
                ack_prev = ap_ack;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_ack: got toggle expected none (cycle %0d)", cyc);
                end else begin
                    e_mon  = exp_q.pop_front();
                    t0_mon = (e_mon.t0 < 0) ? last_ack + 1 : e_mon.t0;
                    chk("rsp_rdata", rsp_rdata, e_mon.rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(e_mon.err));
                    chk("rsp_timeout", 32'(rsp_timeout), 32'(e_mon.to));
                    chk("ack_latency", 32'(cyc - t0_mon), 32'(e_mon.lat));
                    chk("trans_mask", 32'(tmask), 32'(e_mon.mask));
                    chk("trans_cycles", 32'(tcnt), 32'(e_mon.tcnt));
                    chk("slvaddr", slvaddr, e_mon.addr);
                    chk("slvwdata", slvwdata, e_mon.wdata);
                    chk("slvwrite", 32'(slvwrite), 32'(e_mon.wr));
                    chk("slvsize", 32'(slvsize), 32'(e_mon.size));
                end
                last_ack = cyc;
                ack_cnt++;
                tmask = '0;
                tcnt  = 0;
            end
        end
    end

    // Slave model: ready pulse cfg_wait cycles into WAIT; checks the bus is held.
    int idx;
    initial begin
        slvready = '0;
        slvresp  = '0;
        forever begin
            @(negedge dclk);
            if (!apreset && slvtrans != '0) begin
                idx = slvtrans[1] ? 1 : 0;
                repeat (cfg_wait + 1) @(negedge dclk);
                if (chk_hold) begin
                    chk("hold_addr", slvaddr, hold_addr);
                    chk("hold_wdata", slvwdata, hold_wdata);
                    chk("hold_write", 32'(slvwrite), 32'(hold_wr));
                end
                slvready[idx] = 1'b1;
                slvresp[idx]  = cfg_resp;
                @(negedge dclk);
                slvready = '0;
                slvresp  = '0;
            end
        end
    end

    task automatic wait_acks(input int target);
        int n = 0;
        while (ack_cnt < target && n < 60) begin
            @(negedge dclk);
            n++;
        end
        if (ack_cnt < target) begin
            tests++;
            fails++;
            $display("FAIL ack_wait: got %0d acks expected %0d", ack_cnt, target);
            exp_q.delete();
        end
    endtask

    task automatic issue(input logic [3:0] apsel, input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int wait_c, input logic resp,
                         input logic [31:0] ex_rdata, input logic ex_err, input logic ex_to,
                         input int lat, input logic [1:0] mask, input int nreq);
        exp_t e;
        int   start;
        cfg_wait   = wait_c;
        cfg_resp   = resp;
        hold_addr  = addr;
        hold_wdata = wdata;
        hold_wr    = wr;
        @(negedge dclk);
        req_apsel = apsel;
        req_write = wr;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        e.rdata = ex_rdata; e.err = ex_err; e.to = ex_to; e.lat = lat;
        e.t0 = cyc + 1; e.mask = mask; e.tcnt = (mask != '0) ? 1 : 0;
        e.addr = addr; e.wdata = wdata; e.wr = wr; e.size = size;
        exp_q.push_back(e);
        if (nreq > 1) begin
            e.t0 = -1;
            exp_q.push_back(e);
        end
        start  = ack_cnt;
        dp_req = ~dp_req;
        if (nreq > 1) begin
            // Protocol-violating re-toggle while the first transfer is in WAIT.
            repeat (3) @(negedge dclk);
            dp_req = ~dp_req;
        end
        wait_acks(start + nreq);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        apreset   = 1'b1;
        dp_req    = 1'b0;
        req_apsel = '0;
        req_write = 1'b0;
        req_size  = '0;
        req_addr  = '0;
        req_wdata = '0;
        deviceen  = 2'b11;
        slvrdata  = {32'hCAFE0001, 32'h0A0A5A5A};
        repeat (3) @(negedge dclk);
        chk_reset_state();
        apreset = 1'b0;

        // apsel, wr, size, addr, wdata, wait, resp, rdata, err, to, latency, mask, nreq
        issue(4'd1, 1'b0, 2'b10, 32'h2000_0010, 32'h0, 0, 1'b0, 32'hCAFE0001, 1'b0, 1'b0, 3, 2'b10, 1);
        issue(4'd0, 1'b1, 2'b10, 32'hE000_ED00, 32'h5, 4, 1'b0, 32'h0, 1'b0, 1'b0, 7, 2'b01, 1);
        issue(4'd5, 1'b0, 2'b10, 32'h0000_0004, 32'h0, 0, 1'b0, 32'h0, 1'b0, 1'b0, 1, 2'b00, 1);
        deviceen = 2'b10;
        issue(4'd0, 1'b0, 2'b10, 32'h0000_0008, 32'h0, 0, 1'b0, 32'h0, 1'b1, 1'b0, 1, 2'b00, 1);
        deviceen = 2'b11;
        issue(4'd0, 1'b0, 2'b10, 32'h1000_0000, 32'h0, 8, 1'b0, 32'h0, 1'b1, 1'b1, 10, 2'b01, 1);
        issue(4'd0, 1'b0, 2'b01, 32'h1000_0002, 32'h0, 1, 1'b0, 32'h0A0A5A5A, 1'b0, 1'b0, 4, 2'b01, 1);
        issue(4'd1, 1'b0, 2'b10, 32'h3000_0000, 32'h0, 2, 1'b1, 32'h0, 1'b1, 1'b0, 5, 2'b10, 1);
        issue(4'd1, 1'b0, 2'b00, 32'h3000_0001, 32'h0, 3, 1'b0, 32'hCAFE0001, 1'b0, 1'b0, 6, 2'b10, 2);

        // Reset while the bridge sits in WAIT.
        cfg_wait = 20;
        chk_hold = 1'b0;
        @(negedge dclk);
        req_apsel = 4'd0;
        req_addr  = 32'h4000_0000;
        dp_req    = ~dp_req;
        repeat (4) @(negedge dclk);
        chk("no_ack_in_wait", 32'(ap_ack), 32'h1);
        apreset = 1'b1;
        dp_req  = 1'b0;
        @(negedge dclk);
        chk_reset_state();
        @(negedge dclk);
        apreset = 1'b0;
        repeat (25) @(negedge dclk);
        chk_hold = 1'b1;

        issue(4'd1, 1'b0, 2'b10, 32'h2000_0020, 32'h0, 0, 1'b0, 32'hCAFE0001, 1'b0, 1'b0, 3, 2'b10, 1);
        issue(4'd1, 1'b1, 2'b01, 32'h2000_0030, 32'h1234_5678, 0, 1'b1, 32'h0, 1'b1, 1'b0, 3, 2'b10, 1);

        repeat (3) @(negedge dclk);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
